// File: rtl/threshold_monitor.sv
// Persistence-filtered, hysteretic threshold alarm on a stream of unsigned samples.
// Also counts alarm entries (saturating) and tracks min/max of accepted samples.
module threshold_monitor #(
    parameter int WIDTH   = 8,
    parameter int PERSIST = 3,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    input  logic [WIDTH-1:0] thr_hi,
    input  logic [WIDTH-1:0] thr_lo,
    input  logic             clear,
    output logic             alarm,
    output logic             alarm_rise,
    output logic             alarm_fall,
    output logic [CNT_W-1:0] event_count,
    output logic [WIDTH-1:0] max_seen,
    output logic [WIDTH-1:0] min_seen
);

    typedef enum logic [1:0] {NORMAL, ARMING, ALARM, DISARMING} state_t;

    localparam logic [3:0] PERSIST_C = 4'(PERSIST);

    state_t     state;
    state_t     next_state;
    logic [3:0] cnt;
    logic [3:0] next_cnt;
    logic [3:0] cnt_inc;
    logic       above;
    logic       below;
    logic       enter_alarm;
    logic       enter_normal;

    assign above   = sample > thr_hi;
    assign below   = sample < thr_lo;
    assign cnt_inc = cnt + 4'd1;

    // State and persistence counter; clear behaves like a synchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= NORMAL;
            cnt   <= 4'd0;
        end else if (clear) begin
            state <= NORMAL;
            cnt   <= 4'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_comb begin
        next_state   = state;
        next_cnt     = cnt;
        enter_alarm  = 1'b0;
        enter_normal = 1'b0;
        if (sample_valid) begin
            case (state)
                NORMAL: begin
                    if (above) begin
                        if (PERSIST_C == 4'd1) begin
                            next_state  = ALARM;
                            enter_alarm = 1'b1;
                        end else begin
                            next_state = ARMING;
                            next_cnt   = 4'd1;
                        end
                    end
                end
                ARMING: begin
                    if (above) begin
                        if (cnt_inc == PERSIST_C) begin
                            next_state  = ALARM;
                            next_cnt    = 4'd0;
                            enter_alarm = 1'b1;
                        end else begin
                            next_cnt = cnt_inc;
                        end
                    end else begin
                        next_state = NORMAL;
                        next_cnt   = 4'd0;
                    end
                end
                ALARM: begin
                    if (below) begin
                        if (PERSIST_C == 4'd1) begin
                            next_state   = NORMAL;
                            enter_normal = 1'b1;
                        end else begin
                            next_state = DISARMING;
                            next_cnt   = 4'd1;
                        end
                    end
                end
                DISARMING: begin
                    if (below) begin
                        if (cnt_inc == PERSIST_C) begin
                            next_state   = NORMAL;
                            next_cnt     = 4'd0;
                            enter_normal = 1'b1;
                        end else begin
                            next_cnt = cnt_inc;
                        end
                    end else begin
                        // Falling back into ALARM from DISARMING is not a new entry.
                        next_state = ALARM;
                        next_cnt   = 4'd0;
                    end
                end
                default: begin
                    next_state = NORMAL;
                    next_cnt   = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        alarm = (state == ALARM) || (state == DISARMING);
    end

    // Registered pulses, saturating entry counter and min/max tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_rise  <= 1'b0;
            alarm_fall  <= 1'b0;
            event_count <= '0;
            max_seen    <= '0;
            min_seen    <= '1;
        end else if (clear) begin
            alarm_rise  <= 1'b0;
            alarm_fall  <= 1'b0;
            event_count <= '0;
            max_seen    <= '0;
            min_seen    <= '1;
        end else begin
            alarm_rise <= enter_alarm;
            alarm_fall <= enter_normal;
            if (enter_alarm && (event_count != '1)) begin
                event_count <= event_count + CNT_W'(1);
            end
            if (sample_valid) begin
                if (sample > max_seen) begin
                    max_seen <= sample;
                end
                if (sample < min_seen) begin
                    min_seen <= sample;
                end
            end
        end
    end

endmodule

// File: tb/tb_threshold_monitor.sv
// Directed, table-driven bench for threshold_monitor with thr_hi=200, thr_lo=100, PERSIST=3.
// A second instance with a 2-bit entry counter shares the inputs to exercise saturation.
module tb_threshold_monitor;

    typedef struct {
        logic       valid;
        logic       clr;
        logic [7:0] smp;
        logic       ea;
        logic       er;
        logic       ef;
        logic [7:0] ec;
        logic [7:0] emax;
        logic [7:0] emin;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_valid = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] sample = 8'd0;
    logic [7:0] thr_hi = 8'd200;
    logic [7:0] thr_lo = 8'd100;

    logic       alarm;
    logic       alarm_rise;
    logic       alarm_fall;
    logic [7:0] event_count;
    logic [7:0] max_seen;
    logic [7:0] min_seen;

    logic       s_alarm;
    logic       s_rise;
    logic       s_fall;
    logic [1:0] s_count;
    logic [7:0] s_max;
    logic [7:0] s_min;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    threshold_monitor #(.WIDTH(8), .PERSIST(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
        .thr_hi(thr_hi), .thr_lo(thr_lo), .clear(clear),
        .alarm(alarm), .alarm_rise(alarm_rise), .alarm_fall(alarm_fall),
        .event_count(event_count), .max_seen(max_seen), .min_seen(min_seen)
    );

    threshold_monitor #(.WIDTH(8), .PERSIST(3), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
        .thr_hi(thr_hi), .thr_lo(thr_lo), .clear(clear),
        .alarm(s_alarm), .alarm_rise(s_rise), .alarm_fall(s_fall),
        .event_count(s_count), .max_seen(s_max), .min_seen(s_min)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic v, input logic c, input logic [7:0] s,
                                input logic a, input logic r, input logic f,
                                input logic [7:0] n, input logic [7:0] mx, input logic [7:0] mn);
        vec_t t;
        t.valid = v; t.clr = c; t.smp = s;
        t.ea = a; t.er = r; t.ef = f;
        t.ec = n; t.emax = mx; t.emin = mn;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic ea, input logic er, input logic ef,
                            input logic [7:0] ec, input logic [7:0] emax, input logic [7:0] emin);
        checkOutput({tag, ".alarm"}, 32'(alarm), 32'(ea));
        checkOutput({tag, ".rise"}, 32'(alarm_rise), 32'(er));
        checkOutput({tag, ".fall"}, 32'(alarm_fall), 32'(ef));
        checkOutput({tag, ".count"}, 32'(event_count), 32'(ec));
        checkOutput({tag, ".max"}, 32'(max_seen), 32'(emax));
        checkOutput({tag, ".min"}, 32'(min_seen), 32'(emin));
    endtask

    task automatic applyStimulus(input logic v, input logic c, input logic [7:0] s);
        @(negedge clk);
        sample_valid = v;
        clear = c;
        sample = s;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        // Persistence entry, then a pulse-only-one-cycle check and a clear that drops alarm.
        vecs.push_back(mk(1, 0, 210, 0, 0, 0, 0, 210, 210));
        vecs.push_back(mk(1, 0, 220, 0, 0, 0, 0, 220, 210));
        vecs.push_back(mk(1, 0, 230, 1, 1, 0, 1, 230, 210));
        vecs.push_back(mk(0, 0, 0,   1, 0, 0, 1, 230, 210));
        vecs.push_back(mk(0, 1, 0,   0, 0, 0, 0, 0,   255));
        // Equality with thr_hi breaks the streak.
        vecs.push_back(mk(1, 0, 210, 0, 0, 0, 0, 210, 210));
        vecs.push_back(mk(1, 0, 220, 0, 0, 0, 0, 220, 210));
        vecs.push_back(mk(1, 0, 200, 0, 0, 0, 0, 220, 200));
        vecs.push_back(mk(1, 0, 230, 0, 0, 0, 0, 230, 200));
        vecs.push_back(mk(1, 0, 240, 0, 0, 0, 0, 240, 200));
        vecs.push_back(mk(1, 0, 250, 1, 1, 0, 1, 250, 200));
        // Hysteresis release; 100 equals thr_lo and restarts the streak.
        vecs.push_back(mk(1, 0, 90,  1, 0, 0, 1, 250, 90));
        vecs.push_back(mk(1, 0, 90,  1, 0, 0, 1, 250, 90));
        vecs.push_back(mk(1, 0, 100, 1, 0, 0, 1, 250, 90));
        vecs.push_back(mk(1, 0, 90,  1, 0, 0, 1, 250, 90));
        vecs.push_back(mk(1, 0, 90,  1, 0, 0, 1, 250, 90));
        vecs.push_back(mk(1, 0, 90,  0, 0, 1, 1, 250, 90));
        vecs.push_back(mk(0, 0, 0,   0, 0, 0, 1, 250, 90));
        // Gaps in sample_valid keep the streak alive.
        vecs.push_back(mk(1, 0, 210, 0, 0, 0, 1, 250, 90));
        for (int k = 0; k < 4; k++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 250, 90));
        vecs.push_back(mk(1, 0, 220, 0, 0, 0, 1, 250, 90));
        vecs.push_back(mk(0, 0, 0,   0, 0, 0, 1, 250, 90));
        vecs.push_back(mk(1, 0, 230, 1, 1, 0, 2, 250, 90));
        vecs.push_back(mk(0, 0, 0,   1, 0, 0, 2, 250, 90));
        // Clear beats a valid sample in ALARM: sample dropped, no fall pulse.
        vecs.push_back(mk(1, 1, 5,   0, 0, 0, 0, 0,   255));
        vecs.push_back(mk(0, 0, 0,   0, 0, 0, 0, 0,   255));

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkAll("reset", 0, 0, 0, 0, 0, 255);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].valid, vecs[i].clr, vecs[i].smp);
            checkAll($sformatf("vec%0d", i), vecs[i].ea, vecs[i].er, vecs[i].ef,
                     vecs[i].ec, vecs[i].emax, vecs[i].emin);
        end

        // rst between the 2nd and 3rd above sample: alarm must never rise.
        applyStimulus(1, 0, 210);
        applyStimulus(1, 0, 220);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkAll("rst_arming", 0, 0, 0, 0, 0, 255);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1, 0, 230);
        checkOutput("rst_arming.after1", 32'(alarm), 32'd0);
        applyStimulus(1, 0, 240);
        checkOutput("rst_arming.after2", 32'(alarm), 32'd0);
        applyStimulus(0, 1, 0);

        // rst mid-DISARMING drops alarm immediately without a fall pulse.
        applyStimulus(1, 0, 210);
        applyStimulus(1, 0, 220);
        applyStimulus(1, 0, 230);
        applyStimulus(1, 0, 90);
        checkOutput("disarm.alarm", 32'(alarm), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst_disarm.alarm", 32'(alarm), 32'd0);
        checkOutput("rst_disarm.fall", 32'(alarm_fall), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 0, 0);
        checkOutput("rst_disarm.fall2", 32'(alarm_fall), 32'd0);

        // Four alarm entries: 8-bit counter reaches 4, 2-bit counter saturates at 3.
        for (int n = 0; n < 4; n++) begin
            applyStimulus(1, 0, 210);
            applyStimulus(1, 0, 220);
            applyStimulus(1, 0, 230);
            applyStimulus(1, 0, 90);
            applyStimulus(1, 0, 90);
            applyStimulus(1, 0, 90);
        end
        checkOutput("sat.small_count", 32'(s_count), 32'd3);
        checkOutput("sat.big_count", 32'(event_count), 32'd4);
        checkOutput("sat.alarm", 32'(alarm), 32'd0);
        checkOutput("sat.small_min", 32'(s_min), 32'd90);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/threshold_monitor.md
# threshold_monitor

Sequential consumer of the magnitude-compare results produced by the comparator stage. It accepts a stream of unsigned samples, compares each against a high and a low threshold, and applies persistence filtering and hysteresis before asserting or releasing an alarm. It also tracks alarm entries and the min/max of accepted samples. It sits downstream of the comparators and feeds status/interrupt logic.

## Interface
- WIDTH, 8, sample and threshold width (unsigned)
- PERSIST, 3, consecutive qualifying samples required to change alarm state; legal range 1..15
- CNT_W, 8, width of the alarm-entry counter
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- sample_valid  input  1  sample is accepted on this clk edge
- sample  input  WIDTH  sample value
- thr_hi  input  WIDTH  alarm-set threshold; sampled on every accepted sample
- thr_lo  input  WIDTH  alarm-release threshold; sampled on every accepted sample
- clear  input  1  synchronous clear of state, counters and min/max
- alarm  output  1  filtered alarm level
- alarm_rise  output  1  one-cycle pulse on alarm entry
- alarm_fall  output  1  one-cycle pulse on alarm release
- event_count  output  CNT_W  number of alarm entries, saturating
- max_seen  output  WIDTH  largest accepted sample
- min_seen  output  WIDTH  smallest accepted sample

## Operation
- Reset values, applied asynchronously by rst:
  - state NORMAL, persistence counter 0, alarm 0, alarm_rise 0, alarm_fall 0, event_count 0
  - max_seen 0, min_seen all-ones
- Per accepted sample:
  - above = sample > thr_hi
  - below = sample < thr_lo
  - Both comparisons are strict and unsigned: equality with a threshold is neither above nor below.
- FSM states and transitions. Only edges with sample_valid=1 advance the FSM; cycles with sample_valid=0 hold state and counter.
  - NORMAL:
    - above with PERSIST=1 -> ALARM.
    - above otherwise -> ARMING, cnt=1.
    - Anything else stays in NORMAL.
  - ARMING:
    - above with cnt+1==PERSIST -> ALARM, cnt=0.
    - above otherwise -> cnt++.
    - Not above -> NORMAL, cnt=0.
  - ALARM:
    - below with PERSIST=1 -> NORMAL.
    - below otherwise -> DISARMING, cnt=1.
    - Anything else stays in ALARM.
  - DISARMING:
    - below with cnt+1==PERSIST -> NORMAL, cnt=0.
    - below otherwise -> cnt++.
    - Not below -> ALARM, cnt=0.
- alarm=1 in ALARM and DISARMING; alarm=0 in NORMAL and ARMING.
- alarm_rise=1 for exactly one cycle after an edge that enters ALARM from NORMAL or ARMING. Returning to ALARM from DISARMING produces no pulse.
- alarm_fall=1 for exactly one cycle after an edge that enters NORMAL from ALARM or DISARMING.
- event_count increments on every edge that raises alarm_rise and saturates at 2^CNT_W-1 (no wrap).
- max_seen/min_seen update on every accepted sample: max_seen=max(max_seen,sample), min_seen=min(min_seen,sample).
- clear=1 forces all reset values on the next edge.
  - clear has priority over sample_valid in the same cycle; that sample is dropped and does not update min/max.
  - No pulses are generated by clear, even when it drops alarm.
- thr_lo > thr_hi is not rejected. The rules above still apply literally: a sample may be both above and below, and each state uses only its own predicate.
- Threshold changes take effect on the next accepted sample. The persistence count is not reset by a threshold change.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Alarm assertion latency: alarm goes high on the clk edge that accepts the PERSIST-th consecutive above sample, so it is visible in the cycle after that sample is presented. Release latency is the same.
- Gaps in sample_valid do not break a streak; only an accepted non-qualifying sample does.
- Pulses deassert on the following edge regardless of sample_valid.
- rst asserted mid-ARMING or mid-DISARMING returns to NORMAL immediately (asynchronously) with alarm=0 and no alarm_fall pulse.
- Back-to-back accepted samples every cycle are supported; throughput is one sample per clock.

## Test plan
All scenarios use WIDTH=8, PERSIST=3, CNT_W=8, thr_hi=200, thr_lo=100.
- Reset, then idle: assert rst, then release -> alarm=0, pulses 0, event_count=0, max_seen=0, min_seen=255.
- Persistence entry: samples 210, 220, 230 on consecutive cycles -> alarm high after the third edge; alarm_rise high for exactly one cycle; event_count=1; max_seen=230, min_seen=210.
- Broken streak and equality:
  - Samples 210, 220, 200, 230, 240 -> alarm stays 0, because 200 equals thr_hi.
  - Continuing with 250 -> alarm rises after 250.
- Hysteresis release: from ALARM, samples 90, 90, 100, 90, 90, 90 -> 100 breaks the streak (equal to thr_lo, no alarm_fall); alarm falls after the sixth sample with a single alarm_fall pulse.
- Valid gaps and saturation:
  - 210, idle 4 cycles, 220, idle, 230 -> alarm rises.
  - With CNT_W=2, four alarm entries -> event_count saturates at 3.
- Clear/reset priority:
  - clear=1 and sample_valid=1 with sample=5 in ALARM -> next cycle all reset values, min_seen=255, no alarm_fall.
  - rst asserted between the 2nd and 3rd above sample -> alarm never rises.
